gg_rdmb_sched: RTL and testbench
================================

# gg_rdmb_sched

Read-side macroblock DMA scheduler. On a frame start it walks the frame in macroblock raster order and issues one AXI4 128-bit read burst of 24 beats per macroblock. It bounds the number of outstanding bursts and tracks read-data completion, so the macroblock stream reaching the chroma DC insert stage arrives in encode order with `last` on every Cr3 beat. It drives only the AR channel; R data passes straight through to the stream path, and this block observes the R handshake.

## Interface
- `ADDR_W`, 32: AXI address width.
- `MBD_W`, 8: width of the macroblock-dimension fields.
- `MAX_OUT`, 4: maximum outstanding read bursts (1..15).

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high reset.
- `cfg_base` in ADDR_W: frame base byte address; bits [8:0] ignored and treated as 0.
- `cfg_mb_w` in MBD_W: frame width in macroblocks.
- `cfg_mb_h` in MBD_W: frame height in macroblocks.
- `start` in 1: one-cycle frame start pulse.
- `busy` out 1: frame in progress.
- `done` out 1: one-cycle pulse when the frame is fully read.
- `ar_addr` out ADDR_W: burst address.
- `ar_len` out 8: constant 23.
- `ar_size` out 3: constant 3'b100.
- `ar_burst` out 2: constant 2'b01 (INCR).
- `ar_valid` out 1: AR request.
- `ar_ready` in 1: AR accept.
- `r_valid` in 1: observed R valid.
- `r_ready` in 1: observed R ready.
- `r_last` in 1: observed R last.
- `err` out 1: sticky beat-count error (see Configuration).

## Operation
- States are IDLE, ISSUE, DRAIN and DONE.
- **IDLE**
  - On `start`, latch `cfg_*`, compute total = w*h (2*MBD_W bits), clear the issue counter, and load `addr_q` = {cfg_base[ADDR_W-1:9], 9'b0}.
  - If total == 0, go to DONE; otherwise go to ISSUE.
- **ISSUE**
  - `ar_valid` = (outstanding < MAX_OUT).
  - On an AR handshake: `addr_q` += 512 (wraps mod 2^ADDR_W), the issue counter increments, and outstanding increments.
  - When the issue counter reaches total, go to DRAIN.
- **Macroblock pitch**: fixed at 512 bytes; 384 bytes carry data and the rest is padding. Because of this pitch and the 512-byte base alignment, no burst ever crosses a 4 KB boundary.
- **DRAIN**: wait for outstanding == 0, then go to DONE.
- **DONE**: `done` = 1 for exactly one cycle, then go to IDLE.
- **Outstanding counter**
  - Decrements on an R handshake (`r_valid && r_ready && r_last`).
  - A simultaneous AR handshake and R-last handshake leaves it unchanged.
  - It never underflows; an R-last with outstanding == 0 is ignored and sets `err` if the feature is enabled.
- **AXI rules**
  - Once `ar_valid` is asserted, `ar_valid` and `ar_addr` hold stable until `ar_ready`.
  - `ar_valid` never drops without a handshake.
- `start` is ignored unless the state is IDLE. `cfg_*` changes while busy have no effect.
- `busy` = (state != IDLE).
- **Reset values**:
  - state IDLE
  - `busy` 0, `done` 0, `ar_valid` 0
  - `ar_addr` 0, outstanding 0, `err` 0
  - `ar_len`, `ar_size`, `ar_burst` are constants
- Reset mid-frame abandons the frame immediately. Outstanding R beats arriving after reset are ignored and do not set `err`; the beat counter is held clear until the first `start`.

## Timing
- `ar_valid` is registered and rises the cycle after `start` is sampled.
- The first burst address equals the aligned base.
- With `ar_ready` held at 1 and no back-pressure, bursts issue on consecutive cycles until MAX_OUT are outstanding.
- `done` asserts 2 cycles after the R-last handshake of the final burst (one cycle into DRAIN→DONE evaluation, one in DONE). When total == 0, `done` asserts 2 cycles after `start`.
- A new `start` is accepted in the cycle after `done`.
- All outputs are registered. There is no combinational path from `ar_ready` or `r_*` to `ar_valid`.

## Configuration
- `GG_RDMB_SCHED_ERR_EN` defined:
  - A 5-bit beat counter counts R handshakes since the last R-last.
  - `err` becomes sticky 1 when `r_last` occurs with count != 23, when a beat occurs at count 23 without `r_last`, or on an R-last with outstanding == 0.
  - `err` clears only on reset.
- Undefined: no beat counter is present and `err` is tied to 0.

## Test plan
- w=2, h=1, base=0x1000_0123, `ar_ready`=1, R returns 24 beats per burst → addresses 0x1000_0000 and 0x1000_0200, `ar_len`=23, `done` pulses once, `busy` falls with it.
- w=4, h=4, MAX_OUT=4, R stalled → exactly 4 AR handshakes, then `ar_valid`=0. Releasing one burst's R data issues exactly 1 more. Total 16 bursts, `done` after the 16th R-last.
- `ar_ready` held 0 for 5 cycles → `ar_valid` and `ar_addr` are stable throughout. Same-cycle AR and R-last handshakes keep outstanding unchanged.
- w=0 or h=0 → no `ar_valid`, `done` 2 cycles after `start`. `start` pulsed while busy → ignored, and the burst count is unchanged.
- Reset asserted mid-ISSUE → next cycle `ar_valid`=0, `busy`=0. A later `start` runs a clean frame with `err`=0.
- With `GG_RDMB_SCHED_ERR_EN`: `r_last` on beat 20 → `err`=1 and stays 1 through `done`. Without the macro, `err`=0 for the same stimulus.

Source files
------------

// File: rtl/gg_rdmb_sched.sv
// Read-side macroblock DMA scheduler: one 24-beat AXI4 read burst per macroblock, bounded outstanding.
// Optional beat-count checking is enabled by defining GG_RDMB_SCHED_ERR_EN.
module gg_rdmb_sched #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned MBD_W   = 8,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [MBD_W-1:0]  cfg_mb_w,
  input  logic [MBD_W-1:0]  cfg_mb_h,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ar_addr,
  output logic [7:0]        ar_len,
  output logic [2:0]        ar_size,
  output logic [1:0]        ar_burst,
  output logic              ar_valid,
  input  logic              ar_ready,
  input  logic              r_valid,
  input  logic              r_ready,
  input  logic              r_last,
  output logic              err
);

  localparam int unsigned TotW = 2 * MBD_W;
  localparam logic [3:0] MaxOut = 4'(MAX_OUT);
  localparam logic [ADDR_W-1:0] Pitch = ADDR_W'(512);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [TotW-1:0]   total_q, total_d;
  logic [TotW-1:0]   issued_q, issued_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        out_q, out_d;
  logic              ar_valid_q, ar_valid_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              ar_hs;
  logic              r_dec;
  logic              unused_base;

  // The low nine base bits are forced to zero, so they never reach the datapath.
  assign unused_base = ^cfg_base[8:0];

  assign ar_hs = ar_valid_q & ar_ready;
  assign r_dec = r_valid & r_ready & r_last & (out_q != 4'd0);

  always_comb begin
    state_d  = state_q;
    total_d  = total_q;
    issued_d = issued_q;
    addr_d   = addr_q;
    out_d    = out_q;

    if (ar_hs && !r_dec) begin
      out_d = out_q + 4'd1;
    end else if (!ar_hs && r_dec) begin
      out_d = out_q - 4'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          total_d  = TotW'(cfg_mb_w) * TotW'(cfg_mb_h);
          issued_d = '0;
          addr_d   = {cfg_base[ADDR_W-1:9], 9'b0};
          state_d  = (total_d == '0) ? StDone : StIssue;
        end
      end
      StIssue: begin
        if (ar_hs) begin
          addr_d   = addr_q + Pitch;
          issued_d = issued_q + TotW'(1);
          if (issued_d == total_q) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (out_d == 4'd0) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A pending request is held until accepted; new requests need credit and remaining work.
    ar_valid_d = (ar_valid_q && !ar_ready) ||
                 ((state_d == StIssue) && (issued_d < total_d) && (out_d < MaxOut));
    done_d     = (state_q == StDone);
    busy_d     = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      total_q    <= '0;
      issued_q   <= '0;
      addr_q     <= '0;
      out_q      <= 4'd0;
      ar_valid_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      total_q    <= total_d;
      issued_q   <= issued_d;
      addr_q     <= addr_d;
      out_q      <= out_d;
      ar_valid_q <= ar_valid_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign ar_addr  = addr_q;
  assign ar_valid = ar_valid_q;
  assign ar_len   = 8'd23;
  assign ar_size  = 3'b100;
  assign ar_burst = 2'b01;

`ifdef GG_RDMB_SCHED_ERR_EN
  logic       armed_q;
  logic [4:0] beat_q;
  logic       err_q;

  // Beats are only judged once a frame has been started after reset, so stale data is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      armed_q <= 1'b0;
      beat_q  <= 5'd0;
      err_q   <= 1'b0;
    end else begin
      if ((state_q == StIdle) && start) begin
        armed_q <= 1'b1;
      end
      if (armed_q && r_valid && r_ready) begin
        if (r_last) begin
          if ((beat_q != 5'd23) || (out_q == 4'd0)) begin
            err_q <= 1'b1;
          end
          beat_q <= 5'd0;
        end else begin
          if (beat_q == 5'd23) begin
            err_q <= 1'b1;
          end
          if (beat_q != 5'd31) begin
            beat_q <= beat_q + 5'd1;
          end
        end
      end
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gg_rdmb_sched.sv
// Directed bench for gg_rdmb_sched: cycle model of the frame walk plus literal spot checks.
module tb_gg_rdmb_sched;

  localparam int AW = 32;
  localparam int MW = 8;
  localparam int MO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] cfg_base;
  logic [MW-1:0] cfg_mb_w;
  logic [MW-1:0] cfg_mb_h;
  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] ar_addr;
  logic [7:0]    ar_len;
  logic [2:0]    ar_size;
  logic [1:0]    ar_burst;
  logic          ar_valid;
  logic          ar_ready;
  logic          r_valid;
  logic          r_ready;
  logic          r_last;
  logic          err;

  gg_rdmb_sched #(
    .ADDR_W (AW),
    .MBD_W  (MW),
    .MAX_OUT(MO)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .cfg_base(cfg_base),
    .cfg_mb_w(cfg_mb_w),
    .cfg_mb_h(cfg_mb_h),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .ar_addr (ar_addr),
    .ar_len  (ar_len),
    .ar_size (ar_size),
    .ar_burst(ar_burst),
    .ar_valid(ar_valid),
    .ar_ready(ar_ready),
    .r_valid (r_valid),
    .r_ready (r_ready),
    .r_last  (r_last),
    .err     (err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

`ifdef GG_RDMB_SCHED_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  // Spec-level model: frame phase, burst counts, credit and expected address.
  typedef enum int {MIdle, MIssue, MDrain, MDone} mph_e;
  mph_e          m_ph = MIdle;
  int            m_total = 0, m_issued = 0, m_out = 0, m_beats = 0;
  bit            m_valid = 0, m_busy = 0, m_done = 0, m_err = 0, m_armed = 0;
  logic [AW-1:0] m_addr = '0;

  always @(posedge clk) begin : model
    bit   ahs, rb, rl;
    int   nout;
    mph_e nph;
    if (reset) begin
      m_ph = MIdle; m_total = 0; m_issued = 0; m_out = 0; m_beats = 0;
      m_valid = 0; m_busy = 0; m_done = 0; m_err = 0; m_armed = 0; m_addr = '0;
    end else begin
      ahs  = m_valid && ar_ready;
      rb   = r_valid && r_ready;
      rl   = rb && r_last;
      nout = m_out + (ahs ? 1 : 0) - ((rl && m_out > 0) ? 1 : 0);
      if (ErrEn && m_armed && rb) begin
        if (r_last) begin
          if (m_beats != 23 || m_out == 0) m_err = 1;
          m_beats = 0;
        end else begin
          if (m_beats == 23) m_err = 1;
          if (m_beats < 31) m_beats++;
        end
      end
      m_done = (m_ph == MDone);
      nph = m_ph;
      case (m_ph)
        MIdle: if (start) begin
          m_total  = int'(cfg_mb_w) * int'(cfg_mb_h);
          m_issued = 0;
          m_addr   = cfg_base & 32'hFFFF_FE00;
          m_armed  = 1;
          nph      = (m_total == 0) ? MDone : MIssue;
        end
        MIssue: if (ahs) begin
          m_issued++;
          m_addr = m_addr + 32'd512;
          if (m_issued == m_total) nph = MDrain;
        end
        MDrain: if (nout == 0) nph = MDone;
        default: nph = MIdle;
      endcase
      m_out   = nout;
      m_ph    = nph;
      m_valid = (m_valid && !ar_ready) || (m_ph == MIssue && m_issued < m_total && m_out < MO);
      m_busy  = (m_ph != MIdle);
    end
  end

  int            hs_cnt = 0;
  int            done_cnt = 0;
  logic [AW-1:0] hs_addr[$];
  bit            pv_valid = 0, pv_ready = 0, pv_reset = 1;
  logic [AW-1:0] pv_addr = '0;

  always @(negedge clk) begin
    chk("ar_valid", 64'(ar_valid), 64'(m_valid));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("done", 64'(done), 64'(m_done));
    chk("err", 64'(err), 64'(m_err));
    chk("ar_addr", 64'(ar_addr), 64'(m_addr));
    chk("ar_len", 64'(ar_len), 64'd23);
    chk("ar_size", 64'(ar_size), 64'd4);
    chk("ar_burst", 64'(ar_burst), 64'd1);
    if (!pv_reset && pv_valid && !pv_ready) begin
      chk("ar_hold_valid", 64'(ar_valid), 64'd1);
      chk("ar_hold_addr", 64'(ar_addr), 64'(pv_addr));
    end
    if (!reset && ar_valid && ar_ready) begin
      hs_cnt++;
      hs_addr.push_back(ar_addr);
    end
    if (done) done_cnt++;
    pv_valid = ar_valid;
    pv_ready = ar_ready;
    pv_addr  = ar_addr;
    pv_reset = reset;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int w, input int h, input logic [AW-1:0] base);
    cfg_mb_w = MW'(w);
    cfg_mb_h = MW'(h);
    cfg_base = base;
    start    = 1'b1;
    tick(1);
    start    = 1'b0;
  endtask

  // Drives one R burst; optionally raises ar_ready together with the last beat.
  task automatic send_burst(input int nbeats, input bit rdy_on_last);
    for (int i = 0; i < nbeats; i++) begin
      r_valid = 1'b1;
      r_ready = 1'b1;
      r_last  = (i == nbeats - 1);
      if (rdy_on_last && i == nbeats - 1) ar_ready = 1'b1;
      tick(1);
    end
    r_valid = 1'b0;
    r_ready = 1'b0;
    r_last  = 1'b0;
  endtask

  task automatic wait_hs(input int target, input int budget);
    int k = 0;
    while (hs_cnt < target && k < budget) begin
      tick(1);
      k++;
    end
    chk("wait_ar_handshake", 64'(hs_cnt >= target), 64'd1);
  endtask

  int h0;

  initial begin
    reset = 1'b1; cfg_base = '0; cfg_mb_w = '0; cfg_mb_h = '0; start = 1'b0;
    ar_ready = 1'b0; r_valid = 1'b0; r_ready = 1'b0; r_last = 1'b0;
    tick(3);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_ar_valid", 64'(ar_valid), 64'd0);
    chk("reset_ar_addr", 64'(ar_addr), 64'd0);
    reset = 1'b0;
    tick(1);

    // Two macroblocks, unaligned base.
    ar_ready = 1'b1;
    h0 = hs_cnt;
    pulse_start(2, 1, 32'h1000_0123);
    chk("a_valid_after_start", 64'(ar_valid), 64'd1);
    wait_hs(h0 + 2, 10);
    chk("a_addr0", 64'(hs_addr[h0]), 64'h1000_0000);
    chk("a_addr1", 64'(hs_addr[h0 + 1]), 64'h1000_0200);
    send_burst(24, 0);
    send_burst(24, 0);
    chk("a_done_early", 64'(done), 64'd0);
    tick(1);
    chk("a_done_lat", 64'(done), 64'd1);
    chk("a_busy_fall", 64'(busy), 64'd0);
    tick(3);
    chk("a_done_once", 64'(done_cnt), 64'd1);

    // 4x4 frame with R stalled: credit limit then one-for-one refill.
    h0 = hs_cnt;
    pulse_start(4, 4, 32'h2000_0000);
    tick(10);
    chk("b_hs_stalled", 64'(hs_cnt - h0), 64'd4);
    chk("b_valid_low", 64'(ar_valid), 64'd0);
    send_burst(24, 0);
    tick(5);
    chk("b_hs_refill", 64'(hs_cnt - h0), 64'd5);
    for (int i = 0; i < 15; i++) send_burst(24, 0);
    tick(1);
    chk("b_done", 64'(done), 64'd1);
    chk("b_hs_total", 64'(hs_cnt - h0), 64'd16);
    chk("b_last_addr", 64'(hs_addr[hs_cnt - 1]), 64'h2000_1E00);
    tick(2);

    // AR back-pressure, then AR and R-last handshakes in the same cycle.
    ar_ready = 1'b0;
    h0 = hs_cnt;
    pulse_start(3, 1, 32'h0000_4000);
    tick(5);
    chk("c_hold_valid", 64'(ar_valid), 64'd1);
    chk("c_hold_addr", 64'(ar_addr), 64'h0000_4000);
    ar_ready = 1'b1;
    tick(1);
    ar_ready = 1'b0;
    send_burst(24, 1);
    chk("c_hs_after_overlap", 64'(hs_cnt - h0), 64'd2);
    send_burst(24, 0);
    send_burst(24, 0);
    tick(1);
    chk("c_done", 64'(done), 64'd1);
    chk("c_hs_total", 64'(hs_cnt - h0), 64'd3);
    tick(2);

    // Empty frame, then start pulsed while busy.
    h0 = hs_cnt;
    pulse_start(0, 5, 32'h0000_8000);
    chk("d_zero_done_early", 64'(done), 64'd0);
    tick(1);
    chk("d_zero_done", 64'(done), 64'd1);
    chk("d_zero_no_ar", 64'(hs_cnt - h0), 64'd0);
    tick(2);
    ar_ready = 1'b1;
    pulse_start(2, 2, 32'h0001_0000);
    tick(2);
    pulse_start(5, 5, 32'h0F00_0000);
    tick(4);
    for (int i = 0; i < 4; i++) send_burst(24, 0);
    tick(1);
    chk("d_done", 64'(done), 64'd1);
    chk("d_hs_total", 64'(hs_cnt - h0), 64'd4);
    tick(2);

    // Reset mid-issue, stray R data, then a clean frame.
    pulse_start(4, 4, 32'h3000_0000);
    tick(2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("e_valid_after_reset", 64'(ar_valid), 64'd0);
    chk("e_busy_after_reset", 64'(busy), 64'd0);
    send_burst(24, 0);
    chk("e_err_stray", 64'(err), 64'd0);
    h0 = hs_cnt;
    pulse_start(1, 1, 32'h3000_0000);
    wait_hs(h0 + 1, 5);
    send_burst(24, 0);
    tick(1);
    chk("e_done", 64'(done), 64'd1);
    chk("e_err_clean", 64'(err), 64'd0);
    tick(2);

    // Short burst: r_last on beat 20.
    h0 = hs_cnt;
    pulse_start(1, 1, 32'h0000_0000);
    wait_hs(h0 + 1, 5);
    send_burst(20, 0);
    chk("f_err_set", 64'(err), 64'(ErrEn));
    tick(1);
    chk("f_done", 64'(done), 64'd1);
    chk("f_err_at_done", 64'(err), 64'(ErrEn));
    tick(3);
    chk("f_err_sticky", 64'(err), 64'(ErrEn));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
